// File: rtl/tea_pkg.sv
// Shared definitions for the TEA decryption array back end.
// Holds the block/word widths, the decryptor pipeline depth, and the
// serializer state encoding used by tea_output_collector.
package tea_pkg;

  localparam int TEA_BLOCK_W    = 64;
  localparam int TEA_WORD_W     = 32;
  localparam int TEA_WARMUP     = 32;
  localparam int TEA_FIFO_DEPTH = 16;

  // Serializer states: no word, high word on the bus, low word on the bus.
  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_HI   = 2'd1,
    SER_LO   = 2'd2
  } ser_state_e;

  // Select the high or low 32-bit half of a 64-bit block.
  function automatic logic [TEA_WORD_W-1:0] tea_half(input logic [TEA_BLOCK_W-1:0] blk,
                                                     input logic                   hi);
    logic [TEA_WORD_W-1:0] w;
    if (hi) begin
      w = blk[TEA_BLOCK_W-1:TEA_WORD_W];
    end else begin
      w = blk[TEA_WORD_W-1:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/tea_block_fifo.sv
// Synchronous 64-bit block FIFO.
// Ports: clk/rst (async active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o is the current head, valid when
// empty_o=0), full_o/empty_o/count_o status. Push and pop in the same
// cycle are legal even when full: the head is read before it is overwritten.
import tea_pkg::*;

module tea_block_fifo #(
  parameter int DEPTH = TEA_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [TEA_BLOCK_W-1:0]  wdata_i,
  input  logic                    pop_i,
  output logic [TEA_BLOCK_W-1:0]  rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [TEA_BLOCK_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [AW:0]            count_q;
  logic [AW:0]            count_d;

  // Occupancy update: count + push - pop.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/tea_output_collector.sv
// Collects the 64-bit TEA plaintext stream, drops the decryptor warm-up
// samples, buffers valid blocks and re-emits them as 32-bit words (high
// word first) under valid/ready.
// Ports: clk, rst (async active-high); ena/in_block64 sample input;
// out_word32/out_valid/out_last/out_ready word stream; warm status;
// overflow sticky loss flag with clr_overflow synchronous clear.
import tea_pkg::*;

module tea_output_collector #(
  parameter int WARMUP = TEA_WARMUP,
  parameter int DEPTH  = TEA_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [TEA_BLOCK_W-1:0] in_block64,
  output logic [TEA_WORD_W-1:0]  out_word32,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   warm,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WARMUP + 1);
  localparam logic [CW-1:0] WARM_MAX = CW'(WARMUP);

  logic [CW-1:0]          warm_cnt_q, warm_cnt_d;
  logic                   warm_q, overflow_q, overflow_d;
  ser_state_e             state_q, state_d;
  logic [TEA_BLOCK_W-1:0] hold_q, hold_d;
  logic [TEA_WORD_W-1:0]  word_q, word_d;
  logic                   valid_q, valid_d, last_q, last_d;

  logic                   push_s, pop_s, full_s, empty_s, drop_s;
  logic [TEA_BLOCK_W-1:0] head_s;
  logic [AW:0]            count_s;

  tea_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i (in_block64),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // Write side: a full FIFO still accepts when the serializer pops this cycle.
  always_comb begin
    push_s = ena && warm_q && (!full_s || pop_s);
    drop_s = ena && warm_q && full_s && !pop_s;
  end

  // Warm-up counter saturates at WARMUP; overflow set takes priority over clear.
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (ena && (warm_cnt_q != WARM_MAX)) begin
      warm_cnt_d = warm_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      warm_cnt_d = warm_cnt_q;
    end
    overflow_d = overflow_q;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Serializer next state; outputs are derived from the next state so they
  // can be registered without adding latency.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop_s   = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          hold_d  = head_s;
          state_d = SER_HI;
        end else begin
          state_d = SER_IDLE;
        end
      end
      SER_HI: begin
        if (out_ready) begin
          state_d = SER_LO;
        end else begin
          state_d = SER_HI;
        end
      end
      SER_LO: begin
        if (out_ready && !empty_s) begin
          pop_s   = 1'b1;
          hold_d  = head_s;
          state_d = SER_HI;
        end else if (out_ready) begin
          state_d = SER_IDLE;
        end else begin
          state_d = SER_LO;
        end
      end
      default: begin
        state_d = SER_IDLE;
      end
    endcase

    valid_d = (state_d != SER_IDLE);
    last_d  = (state_d == SER_LO);
    if (state_d == SER_IDLE) begin
      word_d = {TEA_WORD_W{1'b0}};
    end else begin
      word_d = tea_half(hold_d, state_d == SER_HI);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt_q <= {CW{1'b0}};
      warm_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= SER_IDLE;
      hold_q     <= {TEA_BLOCK_W{1'b0}};
      word_q     <= {TEA_WORD_W{1'b0}};
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      warm_q     <= (warm_cnt_d == WARM_MAX);
      overflow_q <= overflow_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign out_word32 = word_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign warm       = warm_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_tea_output_collector.sv
module tb_tea_output_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [63:0] in_block64;
  logic [31:0] out_word32;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        warm;
  logic        overflow;
  logic        clr_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tea_output_collector #(.WARMUP(32), .DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in_block64   (in_block64),
    .out_word32   (out_word32),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .warm         (warm),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  typedef struct packed {
    logic        ena;
    logic [63:0] data;
    logic        rdy;
    logic        clr;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic        exp_last;
    logic        exp_warm;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [63:0] d, input logic r, input logic c);
    ena          = e;
    in_block64   = d;
    out_ready    = r;
    clr_overflow = c;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic [63:0] d, input logic r,
                              input logic v, input logic [31:0] w, input logic l);
    vec_t x;
    x.ena = e; x.data = d; x.rdy = r; x.clr = 1'b0;
    x.exp_valid = v; x.exp_word = w; x.exp_last = l;
    x.exp_warm = 1'b1; x.exp_ovf = 1'b0;
    return x;
  endfunction

  logic [31:0] got_w [$];
  logic        got_l [$];

  // Drain with out_ready=1 and ena=0, recording every accepted word.
  task automatic drain(input int budget);
    int n;
    got_w.delete();
    got_l.delete();
    n = 0;
    while (n < budget) begin
      if (out_valid) begin
        got_w.push_back(out_word32);
        got_l.push_back(out_last);
      end
      step(1'b0, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 1'b0);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; in_block64 = 64'd0; out_ready = 1'b0; clr_overflow = 1'b0;

    vecs[0]  = mk(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    vecs[1]  = mk(1'b0, 64'h0,                   1'b0, 1'b1, 32'h0123_4567, 1'b0);
    vecs[2]  = mk(1'b0, 64'h0,                   1'b0, 1'b1, 32'h0123_4567, 1'b0);
    vecs[3]  = mk(1'b0, 64'h0,                   1'b0, 1'b1, 32'h0123_4567, 1'b0);
    vecs[4]  = mk(1'b0, 64'h0,                   1'b0, 1'b1, 32'h0123_4567, 1'b0);
    vecs[5]  = mk(1'b0, 64'h0,                   1'b0, 1'b1, 32'h0123_4567, 1'b0);
    vecs[6]  = mk(1'b0, 64'h0,                   1'b1, 1'b1, 32'h89AB_CDEF, 1'b1);
    vecs[7]  = mk(1'b0, 64'h0,                   1'b0, 1'b1, 32'h89AB_CDEF, 1'b1);
    vecs[8]  = mk(1'b0, 64'h0,                   1'b1, 1'b0, 32'h0000_0000, 1'b0);
    vecs[9]  = mk(1'b1, 64'hA1A2_A3A4_A5A6_A7A8, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
    vecs[10] = mk(1'b1, 64'hB1B2_B3B4_B5B6_B7B8, 1'b1, 1'b1, 32'hA1A2_A3A4, 1'b0);
    vecs[11] = mk(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1, 32'hA5A6_A7A8, 1'b1);
    vecs[12] = mk(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1, 32'hB1B2_B3B4, 1'b0);
    vecs[13] = mk(1'b0, 64'h0,                   1'b1, 1'b1, 32'hB5B6_B7B8, 1'b1);
    vecs[14] = mk(1'b0, 64'h0,                   1'b1, 1'b0, 32'h0000_0000, 1'b0);
    vecs[15] = mk(1'b0, 64'h0,                   1'b1, 1'b0, 32'h0000_0000, 1'b0);

    // Reset state
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_word", {32'd0, out_word32}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_warm", {63'd0, warm}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Warm-up discard: 32 samples, warm low when each is taken, nothing emitted
    for (int i = 0; i < 32; i++) begin
      check("wu_warm", {63'd0, warm}, 64'd0);
      step(1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
      check("wu_valid", {63'd0, out_valid}, 64'd0);
    end
    check("wu_done", {63'd0, warm}, 64'd1);

    // Table: first block, backpressure, back-to-back blocks, ena=0 ignored
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ena, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_word", i), {32'd0, out_word32}, {32'd0, vecs[i].exp_word});
      check($sformatf("v%0d_last", i), {63'd0, out_last}, {63'd0, vecs[i].exp_last});
      check($sformatf("v%0d_warm", i), {63'd0, warm}, {63'd0, vecs[i].exp_warm});
      check($sformatf("v%0d_ovf", i), {63'd0, overflow}, {63'd0, vecs[i].exp_ovf});
    end

    // Overflow: 17 blocks fit (16 FIFO + hold), the 18th is dropped
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 64'(i), 1'b0, 1'b0);
      if (i == 17) check("ovf_17", {63'd0, overflow}, 64'd0);
      if (i == 18) check("ovf_18", {63'd0, overflow}, 64'd1);
    end
    step(1'b0, 64'd0, 1'b0, 1'b1);
    check("ovf_clr", {63'd0, overflow}, 64'd0);
    // Drop and clear in the same cycle: set wins
    step(1'b1, 64'h99, 1'b0, 1'b1);
    check("race_set", {63'd0, overflow}, 64'd1);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    check("race_clr", {63'd0, overflow}, 64'd0);

    drain(60);
    check("drain_cnt", 64'(got_w.size()), 64'd34);
    if (got_w.size() == 34) begin
      for (int k = 0; k < 17; k++) begin
        check($sformatf("drain_hi%0d", k + 1), {32'd0, got_w[2*k]}, 64'd0);
        check($sformatf("drain_lo%0d", k + 1), {32'd0, got_w[2*k+1]}, 64'(k + 1));
        check($sformatf("drain_l%0d", k + 1), {62'd0, got_l[2*k], got_l[2*k+1]}, 64'd1);
      end
    end
    check("drain_idle", {63'd0, out_valid}, 64'd0);

    // Reset mid-transfer during LO
    step(1'b1, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0);
    check("mid_hi", {32'd0, out_word32}, 64'hCAFE_F00D);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    check("mid_lo", {63'd0, out_last}, 64'd1);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_word", {32'd0, out_word32}, 64'd0);
    check("mrst_last", {63'd0, out_last}, 64'd0);
    check("mrst_warm", {63'd0, warm}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ena gating: 20 samples, 10 idle cycles, then 12 more to finish warm-up
    for (int i = 0; i < 20; i++) step(1'b1, 64'hAAAA_0000_0000_0000 | 64'(i), 1'b1, 1'b0);
    check("gate_20", {63'd0, warm}, 64'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 64'hBAD0_0000_0000_0000 | 64'(i), 1'b1, 1'b0);
    check("gate_idle", {63'd0, warm}, 64'd0);
    for (int i = 0; i < 11; i++) step(1'b1, 64'hCCCC_0000_0000_0000 | 64'(i), 1'b1, 1'b0);
    check("gate_31", {63'd0, warm}, 64'd0);
    check("gate_nov", {63'd0, out_valid}, 64'd0);
    step(1'b1, 64'hCCCC_0000_0000_00FF, 1'b1, 1'b0);
    check("gate_32", {63'd0, warm}, 64'd1);
    step(1'b0, 64'hFFFF_EEEE_DDDD_CCCC, 1'b1, 1'b0);
    step(1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
    drain(8);
    check("gate_cnt", 64'(got_w.size()), 64'd2);
    if (got_w.size() == 2) begin
      check("gate_w0", {32'd0, got_w[0]}, 64'h1111_2222);
      check("gate_w1", {32'd0, got_w[1]}, 64'h3333_4444);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
